pipe_stage_elastic: RTL and testbench

Parametrised pipeline register that replaces the fixed-width stall/erase flip-flop stage between datapath stages (fetch→decode, decode→ALU, ALU→writeback). It is a DEPTH-entry elastic buffer with a valid/ready handshake, a synchronous flush and a programmable reset value. Stages can decouple under backpressure without a global stall network, and occupancy is reported to the hazard logic.

---
 rtl/pipe_stage_elastic.sv | 97 +++++++++
 tb/tb_pipe_stage_elastic.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline register: DEPTH-entry circular buffer with valid/ready handshake,
// synchronous flush, programmable empty-output value and occupancy report.
module pipe_stage_elastic #(
   parameter int unsigned       WIDTH       = 32,
   parameter int unsigned       DEPTH       = 2,
   parameter logic [WIDTH-1:0]  RESET_VALUE = '0,
   parameter int unsigned       CNT_W       = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WIDTH-1:0]  in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WIDTH-1:0]  out_data,
   input  logic              flush,
   output logic [CNT_W-1:0]  count,
   output logic              overflow_err
);

   localparam int unsigned      PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             overflow_q, overflow_d;
   logic             stall_q, stall_d;
   logic [WIDTH-1:0] held_data_q, held_data_d;
   logic             push, pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
   endfunction

   assign in_ready     = (count_q < FULL_CNT);
   assign out_valid    = (count_q != '0);
   assign out_data     = out_valid ? mem_q[rd_ptr_q] : RESET_VALUE;
   assign count        = count_q;
   assign overflow_err = overflow_q;

   always_comb begin
      push        = in_valid && in_ready;
      pop         = out_valid && out_ready;
      mem_d       = mem_q;
      rd_ptr_d    = rd_ptr_q;
      wr_ptr_d    = wr_ptr_q;
      count_d     = count_q;
      // Protocol monitor: a stalled offer must keep its data stable next cycle.
      overflow_d  = overflow_q || (stall_q && in_valid && (in_data != held_data_q));
      stall_d     = in_valid && !in_ready;
      held_data_d = in_data;

      if (flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            mem_d[wr_ptr_q] = in_data;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
         end
         if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
         end
         if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
         end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
      if (reset) begin
         rd_ptr_q    <= '0;
         wr_ptr_q    <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         stall_q     <= 1'b0;
         held_data_q <= '0;
      end else begin
         rd_ptr_q    <= rd_ptr_d;
         wr_ptr_q    <= wr_ptr_d;
         count_q     <= count_d;
         overflow_q  <= overflow_d;
         stall_q     <= stall_d;
         held_data_q <= held_data_d;
      end
   end

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Bench for pipe_stage_elastic: DEPTH=2 and DEPTH=3 instances share stimulus and are
// compared every cycle against a list-based reference model, plus directed tables/sequences.
module tb_pipe_stage_elastic;

   localparam logic [31:0] RV = 32'hDEAD_BEEF;

   logic        clk = 1'b0;
   logic        reset, in_valid, out_ready, flush;
   logic [31:0] in_data;

   logic        in_ready2, out_valid2, ovf2;
   logic [31:0] out_data2;
   logic [1:0]  count2;
   logic        in_ready3, out_valid3, ovf3;
   logic [31:0] out_data3;
   logic [1:0]  count3;

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_en  = 1'b0;

   always #5 clk = ~clk;

   pipe_stage_elastic #(.WIDTH(32), .DEPTH(2), .RESET_VALUE(RV)) u_d2 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready2),
      .in_data(in_data), .out_valid(out_valid2), .out_ready(out_ready),
      .out_data(out_data2), .flush(flush), .count(count2), .overflow_err(ovf2)
   );

   pipe_stage_elastic #(.WIDTH(32), .DEPTH(3), .RESET_VALUE(RV)) u_d3 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready3),
      .in_data(in_data), .out_valid(out_valid3), .out_ready(out_ready),
      .out_data(out_data3), .flush(flush), .count(count3), .overflow_err(ovf3)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Reference model: ordered list per instance (index 0 is the oldest word).
   logic [31:0] mbuf [2][8];
   int          msize [2];
   bit          movf [2];
   bit          mst [2];
   logic [31:0] mpd [2];

   initial begin
      for (int k = 0; k < 2; k++) begin
         msize[k] = 0; movf[k] = 1'b0; mst[k] = 1'b0; mpd[k] = '0;
      end
      forever begin
         @(posedge clk);
         for (int k = 0; k < 2; k++) begin
            int cap;
            bit rdy, vld;
            cap = (k == 0) ? 2 : 3;
            rdy = (msize[k] < cap);
            vld = (msize[k] != 0);
            if (reset) begin
               msize[k] = 0; movf[k] = 1'b0; mst[k] = 1'b0;
            end else begin
               if (mst[k] && in_valid && (in_data != mpd[k])) movf[k] = 1'b1;
               mst[k] = in_valid && !rdy;
               mpd[k] = in_data;
               if (flush) begin
                  msize[k] = 0;
               end else begin
                  if (vld && out_ready) begin
                     for (int j = 0; j < 7; j++) mbuf[k][j] = mbuf[k][j+1];
                     msize[k]--;
                  end
                  if (in_valid && rdy) begin
                     mbuf[k][msize[k]] = in_data;
                     msize[k]++;
                  end
               end
            end
         end
      end
   end

   always begin
      @(posedge clk);
      #1;
      if (chk_en) begin
         chk("m2_valid", 32'(out_valid2), 32'(msize[0] != 0));
         chk("m2_data",  out_data2, (msize[0] != 0) ? mbuf[0][0] : RV);
         chk("m2_ready", 32'(in_ready2), 32'(msize[0] < 2));
         chk("m2_count", 32'(count2), 32'(msize[0]));
         chk("m2_ovf",   32'(ovf2), 32'(movf[0]));
         chk("m3_valid", 32'(out_valid3), 32'(msize[1] != 0));
         chk("m3_data",  out_data3, (msize[1] != 0) ? mbuf[1][0] : RV);
         chk("m3_ready", 32'(in_ready3), 32'(msize[1] < 3));
         chk("m3_count", 32'(count3), 32'(msize[1]));
         chk("m3_ovf",   32'(ovf3), 32'(movf[1]));
      end
   end

   typedef struct {
      logic        v;
      logic [31:0] d;
      logic        ordy;
      logic        ev;
      logic [31:0] ed;
      logic        erdy;
      logic [1:0]  ecnt;
   } vec_t;

   vec_t tbl [8];

   initial begin
      int          nseen;
      logic [31:0] last;

      tbl[0] = '{1'b1, 32'h11, 1'b0, 1'b1, 32'h11, 1'b1, 2'd1};
      tbl[1] = '{1'b1, 32'h22, 1'b0, 1'b1, 32'h11, 1'b0, 2'd2};
      tbl[2] = '{1'b1, 32'h33, 1'b0, 1'b1, 32'h11, 1'b0, 2'd2};
      tbl[3] = '{1'b1, 32'h33, 1'b0, 1'b1, 32'h11, 1'b0, 2'd2};
      tbl[4] = '{1'b1, 32'h33, 1'b1, 1'b1, 32'h22, 1'b1, 2'd1};
      tbl[5] = '{1'b1, 32'h33, 1'b1, 1'b1, 32'h33, 1'b1, 2'd1};
      tbl[6] = '{1'b0, 32'h00, 1'b1, 1'b0, RV,     1'b1, 2'd0};
      tbl[7] = '{1'b0, 32'h00, 1'b1, 1'b0, RV,     1'b1, 2'd0};

      reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; flush = 1'b0;
      cyc(); cyc();
      chk_en = 1'b1;
      reset  = 1'b0;

      // Idle after reset
      for (int i = 0; i < 10; i++) begin
         cyc();
         chk("idle_valid", 32'(out_valid2), 32'd0);
         chk("idle_data",  out_data2, RV);
         chk("idle_ready", 32'(in_ready2), 32'd1);
         chk("idle_count", 32'(count2), 32'd0);
      end

      // Backpressure table on the DEPTH=2 instance
      for (int i = 0; i < 8; i++) begin
         in_valid = tbl[i].v; in_data = tbl[i].d; out_ready = tbl[i].ordy;
         cyc();
         chk("tbl_valid", 32'(out_valid2), 32'(tbl[i].ev));
         chk("tbl_data",  out_data2, tbl[i].ed);
         chk("tbl_ready", 32'(in_ready2), 32'(tbl[i].erdy));
         chk("tbl_count", 32'(count2), 32'(tbl[i].ecnt));
      end

      // Continuous flow, 100 words
      reset = 1'b1; in_valid = 1'b0; cyc(); reset = 1'b0;
      for (int i = 0; i < 100; i++) begin
         in_valid = 1'b1; in_data = 32'(i); out_ready = 1'b1;
         cyc();
         chk("flow_valid", 32'(out_valid2), 32'd1);
         chk("flow_data",  out_data2, 32'(i));
         chk("flow_count", 32'(count2), 32'd1);
      end
      in_valid = 1'b0;
      cyc();
      chk("flow_end_valid", 32'(out_valid2), 32'd0);

      // Flush on DEPTH=3 with concurrent push and pop
      reset = 1'b1; cyc(); reset = 1'b0;
      out_ready = 1'b0;
      in_valid = 1'b1; in_data = 32'hA; cyc();
      in_data = 32'hB; cyc();
      in_data = 32'hC; cyc();
      chk("fl_full_count", 32'(count3), 32'd3);
      in_data = 32'hD; flush = 1'b1; out_ready = 1'b1;
      cyc();
      flush = 1'b0; in_valid = 1'b0;
      chk("fl_count", 32'(count3), 32'd0);
      chk("fl_valid", 32'(out_valid3), 32'd0);
      chk("fl_data",  out_data3, RV);
      in_valid = 1'b1; in_data = 32'hE;
      cyc();
      in_valid = 1'b0;
      nseen = 0; last = '0;
      for (int i = 0; i < 5; i++) begin
         if (out_valid3) begin nseen++; last = out_data3; end
         cyc();
      end
      chk("fl_nwords", 32'(nseen), 32'd1);
      chk("fl_word",   last, 32'hE);

      // Randomized traffic against the model
      reset = 1'b1; cyc(); reset = 1'b0;
      void'($urandom(32'd20240611));
      for (int i = 0; i < 300; i++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         flush     = ($urandom_range(0, 19) == 0);
         in_data   = $urandom;
         cyc();
      end
      flush = 1'b0; in_valid = 1'b0;

      // Reset mid-stream beats push and flush
      reset = 1'b1; cyc(); reset = 1'b0;
      out_ready = 1'b0;
      in_valid = 1'b1; in_data = 32'h100; cyc();
      in_data = 32'h101; cyc();
      chk("rs_pre_count", 32'(count2), 32'd2);
      in_data = 32'h102; flush = 1'b1; reset = 1'b1;
      cyc();
      reset = 1'b0; flush = 1'b0; in_valid = 1'b0;
      chk("rs_count", 32'(count2), 32'd0);
      chk("rs_valid", 32'(out_valid2), 32'd0);
      chk("rs_data",  out_data2, RV);
      chk("rs_ready", 32'(in_ready2), 32'd1);

      // Stalled offer changing data sets the sticky error
      in_valid = 1'b1; in_data = 32'h200; cyc();
      in_data = 32'h201; cyc();
      in_data = 32'h300; cyc();
      chk("ovf_before", 32'(ovf2), 32'd0);
      in_data = 32'h301; cyc();
      chk("ovf_set", 32'(ovf2), 32'd1);
      in_valid = 1'b0; out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk("ovf_sticky", 32'(ovf2), 32'd1);
      end
      flush = 1'b1; cyc(); flush = 1'b0;
      chk("ovf_after_flush", 32'(ovf2), 32'd1);
      reset = 1'b1; cyc(); reset = 1'b0;
      chk("ovf_cleared", 32'(ovf2), 32'd0);
      cyc();

      chk_en = 1'b0;
      cyc();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
